fp_mul_iter: RTL

Parametrised, handshaked IEEE-754-style floating-point multiplier with an iterative shift-add significand datapath. It is the next generation of the team's fixed 32-bit controller/datapath multiplier. Exponent and mantissa widths are generic, so one block serves half, single and custom formats. It adds special-value handling, exception flags and optional round-to-nearest-even. It sits between operand registers and the result bus of the FP unit, one operation in flight at a time.

---
 rtl/fp_mul_iter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/fp_mul_iter.sv
// Iterative shift-add floating-point multiplier with generic exponent/mantissa widths.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_mul_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] reg_1,
  input  logic [W-1:0] reg_2,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int XW = EXP_W + 2;
  localparam int CW = (SW > 1) ? $clog2(SW) : 1;

  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_TOP = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]         QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MUL,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [W-1:0]          op_a, op_b;
  logic                  sign_q;
  logic signed [XW-1:0]  exp_q;
  logic [PW-1:0]         mcand_q;
  logic [SW-1:0]         mplier_q;
  logic [PW-1:0]         acc_q;
  logic [CW-1:0]         cnt_q;
  logic [MAN_W-1:0]      mant_q;
  logic                  guard_q;
  logic                  sticky_q;

  logic                  load;
  logic [W-1:0]          res_n;
  logic [3:0]            flags_n;

  // Operand field decode
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             sign_n;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic             special;
  logic [W-1:0]     spec_res;
  logic [3:0]       spec_flags;
  logic signed [XW-1:0] exp_sum;

  assign ea     = op_a[W-2 -: EXP_W];
  assign eb     = op_b[W-2 -: EXP_W];
  assign ma     = op_a[MAN_W-1:0];
  assign mb     = op_b[MAN_W-1:0];
  assign sign_n = op_a[W-1] ^ op_b[W-1];

  // Subnormals (exp == 0) are treated as zero regardless of mantissa
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (ma == '0);
  assign b_inf  = (eb == '1) && (mb == '0);
  assign a_nan  = (ea == '1) && (ma != '0);
  assign b_nan  = (eb == '1) && (mb != '0);
  assign a_snan = a_nan && !ma[MAN_W-1];
  assign b_snan = b_nan && !mb[MAN_W-1];

  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  always_comb begin
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_res      = QNAN;
      spec_flags[3] = a_snan | b_snan | (a_inf & b_zero) | (b_inf & a_zero);
    end else if (a_inf || b_inf) begin
      spec_res = {sign_n, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      spec_res = {sign_n, {(W-1){1'b0}}};
    end
  end

  // Rounding and final range check
  logic                 inc;
  logic [MAN_W:0]       mant_sum;
  logic signed [XW-1:0] exp_fin;
  logic                 inexact;
  logic [W-1:0]         rnd_res;
  logic [3:0]           rnd_flags;

`ifdef FP_MUL_RNE_EN
  assign inc = guard_q & (sticky_q | mant_q[0]);
`else
  assign inc = 1'b0;
`endif

  assign mant_sum = {1'b0, mant_q} + {{MAN_W{1'b0}}, inc};
  assign exp_fin  = exp_q + $signed({{(XW-1){1'b0}}, mant_sum[MAN_W]});
  assign inexact  = guard_q | sticky_q;

  always_comb begin
    rnd_res   = '0;
    rnd_flags = '0;
    if (exp_fin >= EXP_TOP) begin
      rnd_res   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags = 4'b0101;
    end else if (exp_fin[XW-1] || (exp_fin == '0)) begin
      rnd_res   = {sign_q, {(W-1){1'b0}}};
      rnd_flags = 4'b0011;
    end else begin
      // A rounding carry leaves mant_sum[MAN_W-1:0] all zero, which is the renormalised mantissa
      rnd_res   = {sign_q, exp_fin[EXP_W-1:0], mant_sum[MAN_W-1:0]};
      rnd_flags = {3'b000, inexact};
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    res_n   = '0;
    flags_n = '0;
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    case (state)
      S_IDLE:   if (start) state_n = S_UNPACK;
      S_UNPACK: begin
        if (special) begin
          state_n = S_DONE;
          load    = 1'b1;
          res_n   = spec_res;
          flags_n = spec_flags;
        end else begin
          state_n = S_MUL;
        end
      end
      S_MUL:    if (cnt_q == CW'(SW - 1)) state_n = S_NORM;
      S_NORM:   state_n = S_ROUND;
      S_ROUND: begin
        state_n = S_DONE;
        load    = 1'b1;
        res_n   = rnd_res;
        flags_n = rnd_flags;
      end
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_a     <= '0;
      op_b     <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      result   <= '0;
      flags    <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        result <= res_n;
        flags  <= flags_n;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            op_a <= reg_1;
            op_b <= reg_2;
          end
        end
        S_UNPACK: begin
          sign_q   <= sign_n;
          exp_q    <= exp_sum;
          mcand_q  <= {{SW{1'b0}}, 1'b1, ma};
          mplier_q <= {1'b1, mb};
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        S_MUL: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
        end
        S_NORM: begin
          // Product significand is in [1,4); a set MSB means [2,4) and needs one right shift
          if (acc_q[PW-1]) begin
            mant_q   <= acc_q[PW-2 -: MAN_W];
            guard_q  <= acc_q[MAN_W];
            sticky_q <= |acc_q[MAN_W-1:0];
            exp_q    <= exp_q + 1'b1;
          end else begin
            mant_q   <= acc_q[PW-3 -: MAN_W];
            guard_q  <= acc_q[MAN_W-1];
            sticky_q <= |acc_q[MAN_W-2:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
